// File: rtl/serial_slave_mem.sv
// Bit-serial bus slave with a register-array memory: serial address/burst header,
// then serial write beats, or serial read beats after a programmable wait.
//   state   | meaning
//   S_IDLE  | waiting for m_valid with exactly one of read/write enable
//   S_ADDR  | shifting in address bits (burst bits ride along the first ones)
//   S_WDATA | shifting in write beats, committing each word on its last bit
//   S_WAIT  | counting down the latched read delay, optionally requesting a split
//   S_LOAD  | fetching mem[addr] into the tx shift register
//   S_RDATA | shifting the read word out LSB first under m_ready
module serial_slave_mem #(
   parameter int ADDR_WIDTH      = 12,
   parameter int DATA_WIDTH      = 8,
   parameter int MEM_DEPTH       = 4096,
   parameter int BURST_WIDTH     = 4,
   parameter int DELAY_WIDTH     = 6,
   parameter int SPLIT_THRESHOLD = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DELAY_WIDTH-1:0] slave_delay,
   input  logic                   read_enable,
   input  logic                   write_enable,
   input  logic                   m_valid,
   input  logic                   m_ready,
   input  logic                   rx_address,
   input  logic                   rx_burst,
   input  logic                   rx_data,
   output logic                   s_valid,
   output logic                   s_ready,
   output logic                   tx_data,
   output logic                   split_enable
);

   localparam int ACW = $clog2(ADDR_WIDTH + 1);
   localparam int DCW = $clog2(DATA_WIDTH + 1);
   localparam logic [ACW-1:0]         ADDR_LAST  = ACW'(ADDR_WIDTH - 1);
   localparam logic [ACW-1:0]         BURST_BITS = ACW'(BURST_WIDTH);
   localparam logic [DCW-1:0]         DATA_LAST  = DCW'(DATA_WIDTH - 1);
   localparam logic [DELAY_WIDTH-1:0] DELAY_ONE  = DELAY_WIDTH'(1);
   localparam logic [DELAY_WIDTH:0]   SPLIT_TH   = (DELAY_WIDTH + 1)'(SPLIT_THRESHOLD);
   localparam logic [ADDR_WIDTH:0]    DEPTH_LIM  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WAIT, S_LOAD, S_RDATA} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_write;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [BURST_WIDTH-1:0] r_burst;
   logic [BURST_WIDTH-1:0] r_beat;
   logic [ACW-1:0]         r_acnt;
   logic [DCW-1:0]         r_dcnt;
   logic [DELAY_WIDTH-1:0] r_delay;
   logic                   r_split;
   logic [DATA_WIDTH-1:0]  r_wsh;
   logic [DATA_WIDTH-1:0]  r_tx;
   logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

   logic                   w_start;
   logic                   w_addr_done;
   logic                   w_word_done;
   logic                   w_wbit;
   logic                   w_rbit;
   logic                   w_last_beat;
   logic                   w_in_range;
   logic                   w_mem_we;
   logic [ADDR_WIDTH-1:0]  w_addr_in;
   logic [BURST_WIDTH-1:0] w_burst_in;
   logic [DATA_WIDTH-1:0]  w_wsh_next;

   assign w_start     = m_valid & (read_enable ^ write_enable);
   assign w_addr_done = (r_state == S_ADDR) & m_valid & (r_acnt == ADDR_LAST);
   assign w_word_done = (r_dcnt == DATA_LAST);
   assign w_wbit      = (r_state == S_WDATA) & m_valid;
   assign w_rbit      = (r_state == S_RDATA) & m_ready;
   assign w_last_beat = (r_beat == r_burst);
   assign w_in_range  = {1'b0, r_addr} < DEPTH_LIM;
   assign w_mem_we    = w_wbit & w_word_done & w_in_range;
   // LSB-first serial fields are shifted in from the top and right-shifted down
   assign w_addr_in   = ADDR_WIDTH'(rx_address) << (ADDR_WIDTH - 1);
   assign w_burst_in  = BURST_WIDTH'(rx_burst) << (BURST_WIDTH - 1);
   assign w_wsh_next  = (r_wsh >> 1) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      s_valid      = 1'b0;
      s_ready      = 1'b0;
      tx_data      = 1'b0;
      split_enable = 1'b0;
      case (r_state)
         S_IDLE: begin
            s_ready = 1'b1;
            if (w_start) w_next = S_ADDR;
         end
         S_ADDR: begin
            s_ready = 1'b1;
            if (w_addr_done) begin
               if (r_write)                 w_next = S_WDATA;
               else if (slave_delay == '0)  w_next = S_LOAD;
               else                         w_next = S_WAIT;
            end
         end
         S_WDATA: begin
            s_ready = 1'b1;
            if (w_wbit && w_word_done && w_last_beat) w_next = S_IDLE;
         end
         S_WAIT: begin
            split_enable = r_split;
            if (r_delay == DELAY_ONE) w_next = S_LOAD;
         end
         S_LOAD: w_next = S_RDATA;
         S_RDATA: begin
            s_valid = 1'b1;
            tx_data = r_tx[0];
            if (w_rbit && w_word_done) w_next = w_last_beat ? S_IDLE : S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_burst <= '0;
         r_beat  <= '0;
         r_acnt  <= '0;
         r_dcnt  <= '0;
         r_delay <= '0;
         r_split <= 1'b0;
         r_wsh   <= '0;
         r_tx    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_write <= write_enable;
                  r_addr  <= w_addr_in;
                  r_burst <= w_burst_in;
                  r_acnt  <= ACW'(1);
                  r_beat  <= '0;
                  r_dcnt  <= '0;
               end
            end
            S_ADDR: begin
               if (m_valid) begin
                  r_addr <= (r_addr >> 1) | w_addr_in;
                  if (r_acnt < BURST_BITS) r_burst <= (r_burst >> 1) | w_burst_in;
                  r_acnt <= r_acnt + 1'b1;
                  if (w_addr_done) begin
                     r_delay <= slave_delay;
                     r_split <= ({1'b0, slave_delay} >= SPLIT_TH);
                  end
               end
            end
            S_WDATA: begin
               if (m_valid) begin
                  r_wsh <= w_wsh_next;
                  if (w_word_done) begin
                     r_dcnt <= '0;
                     r_addr <= r_addr + 1'b1;
                     r_beat <= r_beat + 1'b1;
                  end else begin
                     r_dcnt <= r_dcnt + 1'b1;
                  end
               end
            end
            S_WAIT: r_delay <= r_delay - 1'b1;
            S_LOAD: begin
               r_tx   <= w_in_range ? r_mem[r_addr] : '1;
               r_dcnt <= '0;
            end
            S_RDATA: begin
               if (m_ready) begin
                  r_tx <= r_tx >> 1;
                  if (w_word_done) begin
                     r_dcnt <= '0;
                     r_addr <= r_addr + 1'b1;
                     r_beat <= r_beat + 1'b1;
                  end else begin
                     r_dcnt <= r_dcnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // storage is deliberately left out of reset so contents survive an abort
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[r_addr] <= w_wsh_next;
   end

endmodule

// File: tb/tb_serial_slave_mem.sv
// Scoreboard bench for serial_slave_mem: a full-depth and a 3000-word instance
// share stimulus; expected read bits are queued from a reference memory model.
module tb_serial_slave_mem;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] slave_delay;
   logic       read_enable, write_enable, m_valid, m_ready;
   logic       rx_address, rx_burst, rx_data;
   logic       s_valid_a, s_ready_a, tx_data_a, split_a;
   logic       s_valid_b, s_ready_b, tx_data_b, split_b;
   logic       s_valid_o, s_ready_o, tx_data_o, split_o;
   bit         sel;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic       q[$];
   logic [7:0] mdl [4096];

   always #5 clk = ~clk;

   serial_slave_mem dut_full (
      .clk(clk), .reset(reset), .slave_delay(slave_delay),
      .read_enable(read_enable), .write_enable(write_enable),
      .m_valid(m_valid), .m_ready(m_ready),
      .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
      .s_valid(s_valid_a), .s_ready(s_ready_a), .tx_data(tx_data_a),
      .split_enable(split_a)
   );

   serial_slave_mem #(.MEM_DEPTH(3000)) dut_small (
      .clk(clk), .reset(reset), .slave_delay(slave_delay),
      .read_enable(read_enable), .write_enable(write_enable),
      .m_valid(m_valid), .m_ready(m_ready),
      .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
      .s_valid(s_valid_b), .s_ready(s_ready_b), .tx_data(tx_data_b),
      .split_enable(split_b)
   );

   assign s_valid_o = sel ? s_valid_b : s_valid_a;
   assign s_ready_o = sel ? s_ready_b : s_ready_a;
   assign tx_data_o = sel ? tx_data_b : tx_data_a;
   assign split_o   = sel ? split_b   : split_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_word(input logic [11:0] a);
      if (sel && a >= 12'd3000) return 8'hFF;
      return mdl[a];
   endfunction

   task automatic hdr(input bit wr, input logic [11:0] a, input logic [3:0] b, input int stall_at);
      logic [11:0] sa;
      logic [3:0]  sb;
      sa = a;
      sb = b;
      for (int i = 0; i < 12; i++) begin
         if (i == stall_at) begin
            m_valid    = 1'b0;
            rx_address = ~sa[0];
            @(negedge clk);
         end
         m_valid      = 1'b1;
         write_enable = wr;
         read_enable  = !wr;
         rx_address   = sa[0];
         rx_burst     = sb[0];
         sa = sa >> 1;
         sb = sb >> 1;
         @(negedge clk);
      end
      m_valid      = 1'b0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
   endtask

   task automatic wdata(input logic [7:0] d, input int stall_at);
      logic [7:0] sd;
      sd = d;
      for (int j = 0; j < 8; j++) begin
         if (j == stall_at) begin
            m_valid = 1'b0;
            rx_data = ~sd[0];
            @(negedge clk);
         end
         m_valid = 1'b1;
         rx_data = sd[0];
         sd = sd >> 1;
         @(negedge clk);
      end
      m_valid = 1'b0;
   endtask

   task automatic wr_txn(input logic [11:0] a, input logic [3:0] b, input logic [31:0] ws, input int stall_at);
      logic [11:0] ai;
      logic [31:0] sw;
      ai = a;
      sw = ws;
      hdr(1'b1, a, b, stall_at);
      for (int i = 0; i <= int'(b); i++) begin
         mdl[ai] = sw[7:0];
         wdata(sw[7:0], (i == 0) ? stall_at : -1);
         sw = sw >> 8;
         ai = ai + 12'd1;
      end
   endtask

   task automatic rd_txn(input logic [11:0] a, input logic [3:0] b, input logic [5:0] dly,
                         input bit rdy_toggle, input int stall_at);
      logic [11:0] ai;
      logic [7:0]  w;
      logic [3:0]  pat;
      logic [1:0]  ph;
      logic        e, held_pend, held_val;
      int          k, first, split_cnt, gaps, nxfer, total;
      pat = 4'b1001;
      ph = 2'd0;
      ai = a;
      for (int i = 0; i <= int'(b); i++) begin
         w = exp_word(ai);
         for (int j = 0; j < 8; j++) q.push_back(w[j]);
         ai = ai + 12'd1;
      end
      total = (int'(b) + 1) * 8;
      slave_delay = dly;
      m_ready = 1'b1;
      hdr(1'b0, a, b, stall_at);
      k = 0; first = -1; split_cnt = 0; gaps = 0; nxfer = 0; held_pend = 1'b0; held_val = 1'b0;
      while (nxfer < total && k < 600) begin
         if (split_o) split_cnt++;
         if (s_valid_o) begin
            if (first < 0) first = k;
            if (held_pend) check("rd_tx_hold", tx_data_o, held_val);
            m_ready = rdy_toggle ? pat[ph] : 1'b1;
            ph = ph + 2'd1;
            if (m_ready) begin
               e = q.pop_front();
               check("rd_tx_bit", tx_data_o, e);
               nxfer++;
               held_pend = 1'b0;
            end else begin
               held_pend = 1'b1;
               held_val  = tx_data_o;
            end
         end else if (first >= 0) begin
            gaps++;
         end
         @(negedge clk);
         k++;
      end
      m_ready = 1'b1;
      if (nxfer < total) begin
         check("rd_timeout", nxfer, total);
         q.delete();
      end
      check("rd_latency", first, int'(dly) + 1);
      check("rd_split_cycles", split_cnt, (dly >= 6'd16) ? int'(dly) : 0);
      check("rd_beat_gaps", gaps, int'(b));
      check("rd_end_valid", s_valid_o, 1'b0);
      check("rd_end_ready", s_ready_o, 1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      reset = 1'b0;
      slave_delay = '0;
      read_enable = 1'b0; write_enable = 1'b0;
      m_valid = 1'b0; m_ready = 1'b1;
      rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
      sel = 1'b0;
      for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

      repeat (2) @(negedge clk);
      check("rst_s_valid", s_valid_o, 1'b0);
      check("rst_s_ready", s_ready_o, 1'b1);
      check("rst_tx_data", tx_data_o, 1'b0);
      check("rst_split", split_o, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // single write then read back with a short delay
      wr_txn(12'h005, 4'd0, 32'h000000A5, -1);
      check("t1_idle_ready", s_ready_o, 1'b1);
      rd_txn(12'h005, 4'd0, 6'd3, 1'b0, -1);

      // four-beat burst wrapping past the top of the address space
      wr_txn(12'hFFE, 4'd3, 32'h44332211, 3);
      rd_txn(12'hFFE, 4'd3, 6'd0, 1'b0, -1);

      // split request around the threshold
      rd_txn(12'h005, 4'd0, 6'd20, 1'b0, -1);
      rd_txn(12'h005, 4'd0, 6'd15, 1'b0, -1);
      rd_txn(12'h005, 4'd0, 6'd16, 1'b0, -1);

      // master back-pressure with an address-phase stall
      wr_txn(12'h03C, 4'd0, 32'h0000003C, -1);
      rd_txn(12'h03C, 4'd0, 6'd2, 1'b1, 5);

      // conflicting enables must be ignored
      m_valid = 1'b1; read_enable = 1'b1; write_enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx_address = 1'($urandom_range(0, 1));
         rx_burst   = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (i % 4 == 3) check("t5_both_ready", s_ready_o, 1'b1);
      end
      m_valid = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
      @(negedge clk);
      rd_txn(12'h005, 4'd0, 6'd1, 1'b0, -1);

      // reset in the middle of a read beat
      slave_delay = 6'd0;
      m_ready = 1'b0;
      hdr(1'b0, 12'h005, 4'd0, -1);
      waited = 0;
      while (!s_valid_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("t5_rdata_reached", s_valid_o, 1'b1);
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("t5_rst_s_valid", s_valid_o, 1'b0);
      check("t5_rst_s_ready", s_ready_o, 1'b1);
      check("t5_rst_tx_data", tx_data_o, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rd_txn(12'h005, 4'd0, 6'd0, 1'b0, -1);

      // out-of-range access on the 3000-word instance
      wr_txn(12'hC00, 4'd0, 32'h000000BB, -1);
      sel = 1'b1;
      rd_txn(12'hC00, 4'd0, 6'd0, 1'b0, -1);
      rd_txn(12'h005, 4'd0, 6'd0, 1'b0, -1);
      sel = 1'b0;
      rd_txn(12'hC00, 4'd0, 6'd0, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_slave_mem.md
Name: serial_slave_mem

Overview:
Parametrised bit-serial bus slave with on-chip register-array memory. It supersedes the fixed 12-bit-address / 8-bit-data slave-plus-BRAM pairing.
- Receives serial address and burst length, then either absorbs serial write beats or serves serial read beats after a programmable delay.
- Requests a bus split when the read delay is long.
- Sits on the serial bus fabric as one slave endpoint.

Parameters:
ADDR_WIDTH, 12, serial address bits per transaction
DATA_WIDTH, 8, bits per data beat
MEM_DEPTH, 4096, words of storage; addresses >= MEM_DEPTH are out of range
BURST_WIDTH, 4, serial burst-length bits; must be <= ADDR_WIDTH
DELAY_WIDTH, 6, width of slave_delay
SPLIT_THRESHOLD, 16, slave_delay >= this value triggers split_enable

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
slave_delay  in  DELAY_WIDTH  read wait cycles before first read beat
read_enable  in  1  read request, qualified by m_valid in IDLE
write_enable  in  1  write request, qualified by m_valid in IDLE
m_valid  in  1  master drives valid address/data bit
m_ready  in  1  master accepts tx_data bit
rx_address  in  1  serial address, LSB first
rx_burst  in  1  serial burst length, LSB first; value N means N+1 beats
rx_data  in  1  serial write data, LSB first
s_valid  out  1  tx_data valid
s_ready  out  1  slave accepting rx bits
tx_data  out  1  serial read data, LSB first
split_enable  out  1  split request during long read wait

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - s_valid=0, s_ready=1, tx_data=0, split_enable=0; all counters and shift registers cleared.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts the transaction; an in-progress beat is not written.
- States: IDLE, ADDR, WDATA, WAIT, LOAD, RDATA.
- IDLE (s_ready=1):
  - Condition: m_valid=1 and exactly one of read_enable/write_enable.
  - Action: latch op, sample address bit0 and burst bit0, go to ADDR.
  - Both enables high, or neither: no action, stay IDLE.
- ADDR (s_ready=1):
  - Each cycle with m_valid=1 samples the next address bit; burst bits are sampled alongside the first BURST_WIDTH address bits.
  - m_valid=0 stalls.
  - After bit ADDR_WIDTH-1: write goes to WDATA, read goes to WAIT.
- WDATA (s_ready=1):
  - Each cycle with m_valid=1 shifts in one rx_data bit.
  - On the edge sampling bit DATA_WIDTH-1, the full word is written to mem[addr] on that same edge. Out-of-range writes are dropped.
  - After each beat, addr increments modulo 2^ADDR_WIDTH.
  - Returns to IDLE after beat N+1.
- WAIT (s_ready=0):
  - Counts slave_delay cycles; slave_delay is latched on entry, and 0 means one pass-through cycle skipped (WAIT lasts 0 cycles).
  - split_enable=1 for every WAIT cycle if the latched delay >= SPLIT_THRESHOLD.
  - Goes to LOAD.
- LOAD (s_ready=0, s_valid=0, split_enable=0):
  - One cycle; reads mem[addr] into the tx shift register.
  - Out-of-range reads load all-ones.
  - Goes to RDATA.
- RDATA (s_valid=1, s_ready=0):
  - tx_data = shift register bit0.
  - A bit transfers on a cycle with s_valid and m_ready both 1; the register then shifts right.
  - m_ready=0 holds tx_data stable.
  - After DATA_WIDTH transfers: if beats remain, increment addr and go to LOAD. The delay is applied only before the first beat. Otherwise go to IDLE.
- Latency:
  - Write commit: same edge as last data bit.
  - Read: first s_valid is slave_delay+1 cycles after the last address bit edge.
- Burst counter width is BURST_WIDTH; burst length is never 0 beats.

Test Plan:
1. Write addr 0x005, burst 0, data 0xA5 → mem[5]=0xA5, FSM back to IDLE the cycle after the last bit. Then read 0x005 with slave_delay=3 → split_enable stays 0; s_valid rises 4 cycles after the last address bit; tx_data sequence 1,0,1,0,0,1,0,1.
2. Burst write at 0xFFE, burst=3, data 0x11,0x22,0x33,0x44 → mem[0xFFE]=0x11, mem[0xFFF]=0x22, mem[0x000]=0x33, mem[0x001]=0x44 (wrap). Burst read back → same four words, with s_valid low exactly one cycle between beats.
3. Read with slave_delay=20 → split_enable high for exactly 20 cycles, low in the LOAD cycle. With slave_delay=15 → split_enable never asserts.
4. m_ready toggled 1,0,0,1 during read of 0x3C → tx_data held through the stalls; 8 bits delivered as 0,0,1,1,1,1,0,0.
5. read_enable=write_enable=1 with m_valid=1 → stays IDLE, s_ready=1. Also: reset pulsed low mid-RDATA → s_valid=0 immediately, IDLE, memory intact on re-read.
6. With MEM_DEPTH=3000: write 0xBB to 0xC00 → dropped; read 0xC00 → all-ones 0xFF.
